sync_fifo_wr_arbiter: RTL and testbench

//   Round-robin write-port arbiter for the single-write/multiple-read width-converting sync FIFO.

---
 rtl/sync_fifo_wr_arbiter.sv | 113 +++++++++++
 tb/tb_sync_fifo_wr_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing one FIFO write port among NUM_REQ
// valid/ready producers. A grant holds until last beat, MAX_BURST beats or valid drop.
module sync_fifo_wr_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int W_WIDTH   = 32,
   parameter int MAX_BURST = 4,
   parameter int ID_WIDTH  = $clog2(NUM_REQ)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*W_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]         req_last,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       fifo_wr_en,
   output logic [W_WIDTH-1:0]         fifo_wr_data,
   input  logic                       fifo_full,
   output logic [ID_WIDTH-1:0]        grant_id,
   output logic                       busy
);

   localparam int CNT_WIDTH = $clog2(MAX_BURST + 1);

   typedef enum logic {
      IDLE,
      BURST
   } state_t;

   state_t                 state, state_nxt;
   logic [ID_WIDTH-1:0]    rr_ptr, rr_ptr_nxt;
   logic [ID_WIDTH-1:0]    grant_nxt;
   logic [CNT_WIDTH-1:0]   beat_cnt, beat_cnt_nxt;
   logic [ID_WIDTH-1:0]    winner;
   logic [ID_WIDTH:0]      scan_sum;
   logic                   found;
   logic                   transfer;
   logic [W_WIDTH-1:0]     data_arr [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign data_arr[gi] = req_data[gi*W_WIDTH +: W_WIDTH];
   end

   // Data path is a pure mux; its value only matters while fifo_wr_en is high.
   assign fifo_wr_data = data_arr[grant_id];

   // First valid requester at or after rr_ptr, wrapping at NUM_REQ.
   always_comb begin
      // NOTE: every variable gets a default before any branch, so no latch is inferred.
      found    = 1'b0;
      winner   = '0;
      scan_sum = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         scan_sum = {1'b0, rr_ptr} + (ID_WIDTH+1)'(i);
         if (scan_sum >= (ID_WIDTH+1)'(NUM_REQ))
            scan_sum = scan_sum - (ID_WIDTH+1)'(NUM_REQ);
         if (!found && req_valid[scan_sum[ID_WIDTH-1:0]]) begin
            found  = 1'b1;
            winner = scan_sum[ID_WIDTH-1:0];
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      rr_ptr_nxt   = rr_ptr;
      grant_nxt    = grant_id;
      beat_cnt_nxt = beat_cnt;
      req_ready    = '0;
      fifo_wr_en   = 1'b0;
      transfer     = 1'b0;
      busy         = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               grant_nxt    = winner;
               beat_cnt_nxt = '0;
               state_nxt    = BURST;
            end
         end
         BURST: begin
            busy                = 1'b1;
            req_ready[grant_id] = ~fifo_full;
            transfer            = req_valid[grant_id] & ~fifo_full;
            fifo_wr_en          = transfer;
            if (transfer)
               beat_cnt_nxt = beat_cnt + CNT_WIDTH'(1);
            // A full FIFO stalls the burst without releasing the grant.
            if ((transfer && (req_last[grant_id] || beat_cnt == CNT_WIDTH'(MAX_BURST-1)))
                || !req_valid[grant_id]) begin
               state_nxt  = IDLE;
               rr_ptr_nxt = (grant_id == ID_WIDTH'(NUM_REQ-1)) ? '0 : grant_id + ID_WIDTH'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         beat_cnt <= '0;
         grant_id <= '0;
      end else begin
         // NOTE: non-blocking updates so all state registers change together at the edge.
         state    <= state_nxt;
         rr_ptr   <= rr_ptr_nxt;
         beat_cnt <= beat_cnt_nxt;
         grant_id <= grant_nxt;
      end
   end

endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
// Directed and randomised checks of sync_fifo_wr_arbiter: reset, bursts,
// round robin, backpressure, valid drop, and ordering/starvation scoreboard.
module tb_sync_fifo_wr_arbiter;

   localparam int NUM_REQ   = 4;
   localparam int W_WIDTH   = 32;
   localparam int MAX_BURST = 4;
   localparam int ID_WIDTH  = 2;

   logic                       clk;
   logic                       rst_n;
   logic [NUM_REQ-1:0]         req_valid;
   logic [NUM_REQ*W_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]         req_last;
   logic [NUM_REQ-1:0]         req_ready;
   logic                       fifo_wr_en;
   logic [W_WIDTH-1:0]         fifo_wr_data;
   logic                       fifo_full;
   logic [ID_WIDTH-1:0]        grant_id;
   logic                       busy;

   int n_cmp = 0;
   int n_err = 0;

   // Producer model: packet position, total accepted beats, last-flag mode.
   int pkt_len  [NUM_REQ];
   int beat_idx [NUM_REQ];
   int seq      [NUM_REQ];
   bit last_en  [NUM_REQ];
   bit last_all [NUM_REQ];

   sync_fifo_wr_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .W_WIDTH   (W_WIDTH),
      .MAX_BURST (MAX_BURST),
      .ID_WIDTH  (ID_WIDTH)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_last     (req_last),
      .req_ready    (req_ready),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_wr_data (fifo_wr_data),
      .fifo_full    (fifo_full),
      .grant_id     (grant_id),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] word(input int r, input int s);
      return 32'hC0DE_0000 | (32'(r) << 12) | (32'(s) & 32'hFFF);
   endfunction

   task automatic drive();
      for (int i = 0; i < NUM_REQ; i++) begin
         req_valid[i] = (beat_idx[i] < pkt_len[i]);
         req_last[i]  = req_valid[i] &&
                        (last_all[i] || (last_en[i] && beat_idx[i] == pkt_len[i] - 1));
         req_data[i*W_WIDTH +: W_WIDTH] = word(i, seq[i]);
      end
   endtask

   task automatic advance(input logic [NUM_REQ-1:0] hs);
      for (int i = 0; i < NUM_REQ; i++) begin
         if (hs[i]) begin
            beat_idx[i]++;
            seq[i]++;
         end
      end
   endtask

   task automatic clear_producers();
      for (int i = 0; i < NUM_REQ; i++) begin
         pkt_len[i]  = 0;
         beat_idx[i] = 0;
         seq[i]      = 0;
         last_en[i]  = 1'b0;
         last_all[i] = 1'b0;
      end
      fifo_full = 1'b0;
      drive();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      clear_producers();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic start_pkt(input int r, input int len, input bit with_last);
      pkt_len[r]  = len;
      beat_idx[r] = 0;
      last_en[r]  = with_last;
   endtask

   // One cycle: drive, settle, compare outputs, then clock and record handshakes.
   task automatic run_cycle(input string tag, input logic full, input logic exp_en,
                            input int exp_req, input int exp_seq, input logic exp_busy);
      logic [NUM_REQ-1:0] hs;
      logic [NUM_REQ-1:0] exp_rdy;
      fifo_full = full;
      drive();
      #1;
      exp_rdy = (exp_busy && !full) ? (NUM_REQ'(1) << exp_req) : '0;
      check({tag, ":busy"},  32'(busy), 32'(exp_busy));
      check({tag, ":wr_en"}, 32'(fifo_wr_en), 32'(exp_en));
      check({tag, ":ready"}, 32'(req_ready), 32'(exp_rdy));
      if (exp_busy) check({tag, ":grant"}, 32'(grant_id), 32'(exp_req));
      if (exp_en)   check({tag, ":data"}, fifo_wr_data, word(exp_req, exp_seq));
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      advance(hs);
   endtask

   int exp_seq_rb [NUM_REQ];
   int wait_cnt   [NUM_REQ];
   logic prev_busy;

   initial begin
      rst_n = 1'b0;
      clear_producers();
      #2;
      check("rst:busy",  32'(busy), 32'd0);
      check("rst:wr_en", 32'(fifo_wr_en), 32'd0);
      check("rst:ready", 32'(req_ready), 32'd0);
      check("rst:grant", 32'(grant_id), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset asserted in the middle of a burst on requester 2.
      start_pkt(2, 4, 1'b1);
      run_cycle("t1_arb", 1'b0, 1'b0, 0, 0, 1'b0);
      run_cycle("t1_w0",  1'b0, 1'b1, 2, 0, 1'b1);
      drive();
      #1;
      check("t1_pre:busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("t1_mid:busy",  32'(busy), 32'd0);
      check("t1_mid:wr_en", 32'(fifo_wr_en), 32'd0);
      check("t1_mid:ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      clear_producers();
      #1;
      check("t1_post:grant", 32'(grant_id), 32'd0);
      check("t1_post:busy",  32'(busy), 32'd0);

      // Single requester, 6-beat packet split by MAX_BURST: 1111_0_11.
      do_reset();
      start_pkt(1, 6, 1'b1);
      run_cycle("t2_arb0", 1'b0, 1'b0, 0, 0, 1'b0);
      for (int k = 0; k < 4; k++) run_cycle("t2_wa", 1'b0, 1'b1, 1, k, 1'b1);
      run_cycle("t2_arb1", 1'b0, 1'b0, 0, 0, 1'b0);
      for (int k = 4; k < 6; k++) run_cycle("t2_wb", 1'b0, 1'b1, 1, k, 1'b1);
      run_cycle("t2_end", 1'b0, 1'b0, 0, 0, 1'b0);

      // Round robin: all valid, last every beat.
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) begin
         start_pkt(i, 100, 1'b0);
         last_all[i] = 1'b1;
      end
      for (int k = 0; k < 8; k++) begin
         run_cycle("t3_arb", 1'b0, 1'b0, 0, 0, 1'b0);
         run_cycle("t3_wr",  1'b0, 1'b1, k % NUM_REQ, k / NUM_REQ, 1'b1);
      end

      // Backpressure on requester 2 for 3 cycles.
      do_reset();
      start_pkt(2, 4, 1'b1);
      run_cycle("t4_arb", 1'b0, 1'b0, 0, 0, 1'b0);
      run_cycle("t4_w0",  1'b0, 1'b1, 2, 0, 1'b1);
      for (int k = 0; k < 3; k++) run_cycle("t4_full", 1'b1, 1'b0, 2, 0, 1'b1);
      for (int k = 1; k < 4; k++) run_cycle("t4_wr", 1'b0, 1'b1, 2, k, 1'b1);
      run_cycle("t4_end", 1'b0, 1'b0, 0, 0, 1'b0);

      // Valid drop on requester 1; requester 3 must beat requester 0 next.
      do_reset();
      start_pkt(1, 2, 1'b0);
      start_pkt(3, 2, 1'b1);
      run_cycle("t5_arb", 1'b0, 1'b0, 0, 0, 1'b0);
      run_cycle("t5_w1a", 1'b0, 1'b1, 1, 0, 1'b1);
      run_cycle("t5_w1b", 1'b0, 1'b1, 1, 1, 1'b1);
      start_pkt(0, 1, 1'b1);
      run_cycle("t5_drop", 1'b0, 1'b0, 1, 0, 1'b1);
      run_cycle("t5_arb3", 1'b0, 1'b0, 0, 0, 1'b0);
      run_cycle("t5_w3a",  1'b0, 1'b1, 3, 0, 1'b1);
      run_cycle("t5_w3b",  1'b0, 1'b1, 3, 1, 1'b1);
      run_cycle("t5_arb0", 1'b0, 1'b0, 0, 0, 1'b0);
      run_cycle("t5_w0",   1'b0, 1'b1, 0, 0, 1'b1);
      run_cycle("t5_end",  1'b0, 1'b0, 0, 0, 1'b0);

      // Random scoreboard: ordering, no write while full, bounded waiting.
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) begin
         exp_seq_rb[i] = 0;
         wait_cnt[i]   = 0;
      end
      prev_busy = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         logic [NUM_REQ-1:0] hs;
         fifo_full = ($urandom_range(3) == 0);
         drive();
         #1;
         if (fifo_full) check("rnd:no_wr_full", 32'(fifo_wr_en), 32'd0);
         if (fifo_wr_en) begin
            check("rnd:order", fifo_wr_data, word(int'(grant_id), exp_seq_rb[grant_id]));
            exp_seq_rb[grant_id]++;
         end
         if (busy && !prev_busy) begin
            for (int i = 0; i < NUM_REQ; i++) begin
               if (i == int'(grant_id)) begin
                  wait_cnt[i] = 0;
               end else if (req_valid[i]) begin
                  wait_cnt[i]++;
                  check("rnd:starve", 32'(wait_cnt[i] <= NUM_REQ), 32'd1);
               end
            end
         end
         prev_busy = busy;
         hs = req_valid & req_ready;
         @(posedge clk);
         #1;
         advance(hs);
         for (int i = 0; i < NUM_REQ; i++) begin
            if (beat_idx[i] >= pkt_len[i] && $urandom_range(3) == 0) begin
               start_pkt(i, 1 + $urandom_range(5), ($urandom_range(3) != 0));
               wait_cnt[i] = 0;
            end
         end
      end
      for (int i = 0; i < NUM_REQ; i++)
         check("rnd:progress", 32'(exp_seq_rb[i] > 0), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
